// File: rtl/ahb2_soc_chan_bank_if.sv
// AHB-Lite bus signals of the SoC debugger AHB2 port.
interface ahb2_soc_chan_bank_if;
    logic        AHB2HSEL;
    logic [31:0] AHB2HADDR;
    logic [1:0]  AHB2HTRANS;
    logic        AHB2HWRITE;
    logic [31:0] AHB2HWDATA;
    logic        AHB2HREADYIN;
    logic [31:0] AHB2HRDATA;
    logic        AHB2HREADY;
    logic [1:0]  AHB2HRESP;

    modport master (
        output AHB2HSEL, AHB2HADDR, AHB2HTRANS, AHB2HWRITE, AHB2HWDATA, AHB2HREADYIN,
        input  AHB2HRDATA, AHB2HREADY, AHB2HRESP
    );

    modport slave (
        input  AHB2HSEL, AHB2HADDR, AHB2HTRANS, AHB2HWRITE, AHB2HWDATA, AHB2HREADYIN,
        output AHB2HRDATA, AHB2HREADY, AHB2HRESP
    );
endinterface

// File: rtl/ahb2_soc_chan_bank.sv
// AHB-Lite slave: N_CH measurement channels plus a capture-BRAM read window.
// Define AHB2_ERR_RESP_EN to answer unmapped accesses with a two-cycle ERROR response.
module ahb2_soc_chan_bank #(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned BRAM_AW  = 8,
    parameter int unsigned BRAM_LAT = 2,
    parameter int unsigned MODE_W   = 4
) (
    input  logic                HCLK,
    input  logic                AHB2HRESETn,
    ahb2_soc_chan_bank_if.slave ahb,
    output logic [MODE_W-1:0]   mode_out,
    output logic [N_CH-1:0]     ch_start,
    output logic [N_CH-1:0]     ch_ack,
    input  logic [N_CH-1:0]     ch_ready,
    input  logic [32*N_CH-1:0]  ch_res_a,
    input  logic [32*N_CH-1:0]  ch_res_b,
    output logic [BRAM_AW-1:0]  bram_raddr,
    input  logic [31:0]         bram_rdata
);
`ifdef AHB2_ERR_RESP_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    typedef enum logic [2:0] {StIdle, StWrData, StRdWait, StRdDone, StErr1, StErr2} state_e;
    typedef enum logic [1:0] {ClsReg, ClsCh, ClsBram, ClsUnmap} cls_e;

    state_e             state_q;
    cls_e               cls_q, cls_a;
    logic [11:0]        offs, addr_q;
    logic [2:0]         cnt_q;
    logic [MODE_W-1:0]  mode_q;
    logic [N_CH-1:0]    ctrl_q, ack_q;
    logic [BRAM_AW-1:0] raddr_q;
    logic [31:0]        hrdata_q, rd_val;
    logic               hready_q;
    logic [1:0]         hresp_q;
    logic               accept;
    int unsigned        ch_idx;

    assign offs   = ahb.AHB2HADDR[11:0];
    assign accept = ahb.AHB2HSEL & ahb.AHB2HTRANS[1] & ahb.AHB2HREADYIN;
    assign ch_idx = 32'(addr_q[7:4]) - 32'd1;

    always_comb begin
        cls_a = ClsUnmap;
        if (offs == 12'h000) begin
            cls_a = ClsReg;
        end else if (offs >= 12'h010 && {1'b0, offs} < 13'(16 + 16 * N_CH)) begin
            cls_a = ClsCh;
        end else if (offs >= 12'h400 && {1'b0, offs} < 13'(1024 + (4 << BRAM_AW))) begin
            cls_a = ClsBram;
        end
    end

    always_comb begin
        rd_val = '0;
        unique case (cls_q)
            ClsReg:   rd_val = 32'(mode_q);
            ClsBram:  rd_val = bram_rdata;
            ClsUnmap: rd_val = 32'hDEAD_BEEF;
            ClsCh: begin
                for (int unsigned i = 0; i < N_CH; i++) begin
                    if (ch_idx == i) begin
                        unique case (addr_q[3:2])
                            2'd0: rd_val = {31'b0, ctrl_q[i]};
                            2'd1: rd_val = {31'b0, ch_ready[i]};
                            2'd2: rd_val = ch_res_a[32*i +: 32];
                            2'd3: rd_val = ch_res_b[32*i +: 32];
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge AHB2HRESETn) begin
        if (!AHB2HRESETn) begin
            state_q  <= StIdle;
            cls_q    <= ClsReg;
            addr_q   <= '0;
            cnt_q    <= '0;
            mode_q   <= '0;
            ctrl_q   <= '0;
            ack_q    <= '0;
            raddr_q  <= '0;
            hrdata_q <= '0;
            hready_q <= 1'b1;
            hresp_q  <= 2'b00;
        end else begin
            ack_q <= '0;
            // Write data is valid on the edge that closes the data phase.
            if (state_q == StWrData) begin
                if (cls_q == ClsReg) begin
                    mode_q <= ahb.AHB2HWDATA[MODE_W-1:0];
                end else if (cls_q == ClsCh && addr_q[3:2] == 2'd0) begin
                    for (int unsigned i = 0; i < N_CH; i++) begin
                        if (ch_idx == i) begin
                            ctrl_q[i] <= ahb.AHB2HWDATA[0];
                            ack_q[i]  <= ahb.AHB2HWDATA[1];
                        end
                    end
                end
            end
            unique case (state_q)
                StRdWait: begin
                    if (cnt_q == 3'd0) begin
                        state_q  <= StRdDone;
                        hready_q <= 1'b1;
                        hrdata_q <= rd_val;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                StErr1: begin
                    state_q  <= StErr2;
                    hready_q <= 1'b1;
                end
                default: begin
                    // Ready states: a new address phase may be accepted here.
                    state_q  <= StIdle;
                    hready_q <= 1'b1;
                    hresp_q  <= 2'b00;
                    if (accept) begin
                        addr_q <= offs;
                        cls_q  <= cls_a;
                        if (ErrEn && cls_a == ClsUnmap) begin
                            state_q  <= StErr1;
                            hready_q <= 1'b0;
                            hresp_q  <= 2'b01;
                        end else if (ahb.AHB2HWRITE) begin
                            state_q <= StWrData;
                        end else begin
                            state_q  <= StRdWait;
                            hready_q <= 1'b0;
                            cnt_q    <= (cls_a == ClsBram) ? 3'(BRAM_LAT) : 3'd0;
                            if (cls_a == ClsBram) begin
                                raddr_q <= offs[BRAM_AW+1:2];
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign mode_out       = mode_q;
    assign ch_start       = ctrl_q;
    assign ch_ack         = ack_q;
    assign bram_raddr     = raddr_q;
    assign ahb.AHB2HRDATA = hrdata_q;
    assign ahb.AHB2HREADY = hready_q;
    assign ahb.AHB2HRESP  = ErrEn ? hresp_q : 2'b00;

    logic unused_bits;
    assign unused_bits = ^{ahb.AHB2HADDR[31:12], ahb.AHB2HTRANS[0], ahb.AHB2HWDATA,
                           addr_q[11:8], addr_q[1:0]};
endmodule
